// File: rtl/bounce_box_gen_pkg.sv
// Shared VGA constants, direction encoding and the debug view of the box state
// for the bounce_box_gen pixel generator.
package bounce_box_gen_pkg;

    localparam int VGA_HD  = 640;
    localparam int VGA_VD  = 480;
    localparam int RGB_W   = 12;
    localparam int COORD_W = 12;

    localparam logic [RGB_W-1:0] RGB_BOX_DEF = 12'hF00;
    localparam logic [RGB_W-1:0] RGB_BG_DEF  = 12'h00F;
    localparam logic [RGB_W-1:0] RGB_BLACK   = '0;

    // Idle level of the active-low syncs while the block is held in reset.
    localparam logic SYNC_IDLE = 1'b1;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    typedef struct packed {
        logic [COORD_W-1:0] box_x;
        logic [COORD_W-1:0] box_y;
        dir_e               dir_x;
        dir_e               dir_y;
    } box_dbg_t;

    function automatic logic [COORD_W:0] widen(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/bounce_box_gen_if.sv
// Pixel-timing bus from the VGA sync core into the pixel generator.
interface bounce_box_gen_if;
    import bounce_box_gen_pkg::*;

    // Streaming bus with no back-pressure: the sync core presents a new pixel
    // every clock and video_on qualifies pixel_x/pixel_y as visible.
    logic               video_on;
    logic               hsync_in;
    logic               vsync_in;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;

    modport master (output video_on, hsync_in, vsync_in, pixel_x, pixel_y);
    modport slave  (input  video_on, hsync_in, vsync_in, pixel_x, pixel_y);

endinterface

// File: rtl/bounce_box_gen_box_axis.sv
// One axis of the bouncing box: position register, direction flop and the
// wall rule. hit is a combinational pulse on the enabled edge that bounces.
module bounce_box_gen_box_axis
    import bounce_box_gen_pkg::*;
#(
    parameter int LIMIT = VGA_HD,
    parameter int SIZE  = 32,
    parameter int STEP  = 2,
    parameter int P0    = 304
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] pos,
    output dir_e               dir,
    output logic               hit
);

    localparam logic [COORD_W:0]   LIMIT_W = (COORD_W+1)'(LIMIT);
    localparam logic [COORD_W:0]   SIZE_W  = (COORD_W+1)'(SIZE);
    localparam logic [COORD_W:0]   STEP_W  = (COORD_W+1)'(STEP);
    localparam logic [COORD_W-1:0] P0_C    = COORD_W'(P0);
    localparam logic [COORD_W-1:0] FAR_C   = COORD_W'(LIMIT - SIZE);
    localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);

    logic [COORD_W:0] pos_w;
    logic             hit_far;
    logic             hit_near;

    // One extra bit keeps pos + SIZE + STEP from wrapping near the limit.
    assign pos_w    = widen(pos);
    assign hit_far  = (dir == DIR_INC) && (pos_w + SIZE_W + STEP_W >= LIMIT_W);
    assign hit_near = (dir == DIR_DEC) && (pos_w <= STEP_W);
    assign hit      = en && (hit_far || hit_near);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= P0_C;
            dir <= DIR_INC;
        end else if (en) begin
            if (hit_far) begin
                pos <= FAR_C;
                dir <= DIR_DEC;
            end else if (hit_near) begin
                pos <= '0;
                dir <= DIR_INC;
            end else if (dir == DIR_INC) begin
                pos <= pos + STEP_C;
            end else begin
                pos <= pos - STEP_C;
            end
        end
    end

endmodule

// File: rtl/bounce_box_gen.sv
// Demo pixel source: a solid square that moves once per frame, bounces off the
// visible-area edges, and is drawn with one cycle of latency matched on the syncs.
module bounce_box_gen
    import bounce_box_gen_pkg::*;
#(
    parameter int               HD        = VGA_HD,
    parameter int               VD        = VGA_VD,
    parameter int               SIZE      = 32,
    parameter int               STEP      = 2,
    parameter int               X0        = 304,
    parameter int               Y0        = 224,
    parameter logic [RGB_W-1:0] BOX_COLOR = RGB_BOX_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR  = RGB_BG_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bounce_box_gen_if.slave        vga,
    input  logic                   pause,
    output logic [RGB_W-1:0]       rgb,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic [7:0]             bounce_cnt,
    output logic                   frame_tick,
    output box_dbg_t               dbg
);

    localparam logic [COORD_W-1:0] VD_C   = COORD_W'(VD);
    localparam logic [COORD_W:0]   SIZE_W = (COORD_W+1)'(SIZE);

    logic               tick;
    logic               en;
    logic [COORD_W-1:0] box_x;
    logic [COORD_W-1:0] box_y;
    dir_e               dir_x;
    dir_e               dir_y;
    logic               hit_x;
    logic               hit_y;
    logic [8:0]         cnt_sum;
    logic               in_x;
    logic               in_y;

    // First pixel of the first blanking line: once per frame, never mid-draw.
    assign tick = (vga.pixel_y == VD_C) && (vga.pixel_x == '0);
    assign en   = tick && !pause;

    bounce_box_gen_box_axis #(
        .LIMIT (HD),
        .SIZE  (SIZE),
        .STEP  (STEP),
        .P0    (X0)
    ) u_axis_x (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .pos   (box_x),
        .dir   (dir_x),
        .hit   (hit_x)
    );

    bounce_box_gen_box_axis #(
        .LIMIT (VD),
        .SIZE  (SIZE),
        .STEP  (STEP),
        .P0    (Y0)
    ) u_axis_y (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .pos   (box_y),
        .dir   (dir_y),
        .hit   (hit_y)
    );

    assign dbg = '{box_x: box_x, box_y: box_y, dir_x: dir_x, dir_y: dir_y};

    // A corner hit contributes both axis pulses on the same edge.
    assign cnt_sum = {1'b0, bounce_cnt} + {8'd0, hit_x} + {8'd0, hit_y};

    assign in_x = (widen(vga.pixel_x) >= widen(box_x)) &&
                  (widen(vga.pixel_x) <  widen(box_x) + SIZE_W);
    assign in_y = (widen(vga.pixel_y) >= widen(box_y)) &&
                  (widen(vga.pixel_y) <  widen(box_y) + SIZE_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb        <= RGB_BLACK;
            hsync_out  <= SYNC_IDLE;
            vsync_out  <= SYNC_IDLE;
            bounce_cnt <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick;
            hsync_out  <= vga.hsync_in;
            vsync_out  <= vga.vsync_in;
            bounce_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
            if (!vga.video_on) begin
                rgb <= RGB_BLACK;
            end else if (in_x && in_y) begin
                rgb <= BOX_COLOR;
            end else begin
                rgb <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_bounce_box_gen.sv
// Bench for bounce_box_gen: four parameterisations share one pixel bus and are
// checked against a per-frame motion and draw model kept here.
module tb_bounce_box_gen;
    import bounce_box_gen_pkg::*;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic pause;
    initial forever #10 clk = ~clk;

    bounce_box_gen_if vif ();

    logic [11:0] rgb_w [N];
    logic        hs_w  [N];
    logic        vs_w  [N];
    logic [7:0]  cnt_w [N];
    logic        ft_w  [N];
    box_dbg_t    dbg_w [N];

    bounce_box_gen dut_a (
        .clk(clk), .rst_n(rst_n), .vga(vif.slave), .pause(pause),
        .rgb(rgb_w[0]), .hsync_out(hs_w[0]), .vsync_out(vs_w[0]),
        .bounce_cnt(cnt_w[0]), .frame_tick(ft_w[0]), .dbg(dbg_w[0])
    );

    bounce_box_gen #(.X0(600)) dut_b (
        .clk(clk), .rst_n(rst_n), .vga(vif.slave), .pause(pause),
        .rgb(rgb_w[1]), .hsync_out(hs_w[1]), .vsync_out(vs_w[1]),
        .bounce_cnt(cnt_w[1]), .frame_tick(ft_w[1]), .dbg(dbg_w[1])
    );

    bounce_box_gen #(.X0(606), .Y0(446)) dut_c (
        .clk(clk), .rst_n(rst_n), .vga(vif.slave), .pause(pause),
        .rgb(rgb_w[2]), .hsync_out(hs_w[2]), .vsync_out(vs_w[2]),
        .bounce_cnt(cnt_w[2]), .frame_tick(ft_w[2]), .dbg(dbg_w[2])
    );

    bounce_box_gen #(.HD(34), .VD(34), .X0(0), .Y0(0)) dut_e (
        .clk(clk), .rst_n(rst_n), .vga(vif.slave), .pause(pause),
        .rgb(rgb_w[3]), .hsync_out(hs_w[3]), .vsync_out(vs_w[3]),
        .bounce_cnt(cnt_w[3]), .frame_tick(ft_w[3]), .dbg(dbg_w[3])
    );

    // ---------------- reference model ----------------
    int hd_t [N] = '{640, 640, 640, 34};
    int vd_t [N] = '{480, 480, 480, 34};
    int x0_t [N] = '{304, 600, 606, 0};
    int y0_t [N] = '{224, 224, 446, 0};
    localparam int SZ = 32;
    localparam int ST = 2;

    int          m_x [N];
    int          m_y [N];
    int          m_dx [N];
    int          m_dy [N];
    int          m_cnt [N];
    int          m_ft [N];
    logic [11:0] m_rgb [N];
    logic        m_hs;
    logic        m_vs;

    int n_pass = 0;
    int n_total = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = x0_t[i];  m_y[i] = y0_t[i];
            m_dx[i] = 1;       m_dy[i] = 1;
            m_cnt[i] = 0;      m_ft[i] = 0;
            m_rgb[i] = 12'h000;
        end
        m_hs = 1'b1;
        m_vs = 1'b1;
    endtask

    // Move one frame along one axis; touching or crossing a wall parks the box on it.
    task automatic axis_move(input int lim, inout int p, inout int d, inout int hits);
        int nxt;
        nxt = p + d * ST;
        if (nxt <= 0) begin
            p = 0; d = 1; hits++;
        end else if (nxt + SZ >= lim) begin
            p = lim - SZ; d = -1; hits++;
        end else begin
            p = nxt;
        end
    endtask

    task automatic model_edge(input int px, input int py, input logic von,
                              input logic hs, input logic vs, input logic ps);
        int  hits;
        bit  tk;
        for (int i = 0; i < N; i++) begin
            if (!von)
                m_rgb[i] = 12'h000;
            else if (px >= m_x[i] && px < m_x[i] + SZ && py >= m_y[i] && py < m_y[i] + SZ)
                m_rgb[i] = 12'hF00;
            else
                m_rgb[i] = 12'h00F;
            tk = (py == vd_t[i]) && (px == 0);
            m_ft[i] = tk ? 1 : 0;
            if (tk && !ps) begin
                hits = 0;
                axis_move(hd_t[i], m_x[i], m_dx[i], hits);
                axis_move(vd_t[i], m_y[i], m_dy[i], hits);
                m_cnt[i] = (m_cnt[i] + hits > 255) ? 255 : m_cnt[i] + hits;
            end
        end
        m_hs = hs;
        m_vs = vs;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s rgb[%0d]", tag, i),   int'(rgb_w[i]), int'(m_rgb[i]));
            chk($sformatf("%s hs[%0d]", tag, i),    int'(hs_w[i]), int'(m_hs));
            chk($sformatf("%s vs[%0d]", tag, i),    int'(vs_w[i]), int'(m_vs));
            chk($sformatf("%s ft[%0d]", tag, i),    int'(ft_w[i]), m_ft[i]);
            chk($sformatf("%s cnt[%0d]", tag, i),   int'(cnt_w[i]), m_cnt[i]);
            chk($sformatf("%s x[%0d]", tag, i),     int'(dbg_w[i].box_x), m_x[i]);
            chk($sformatf("%s y[%0d]", tag, i),     int'(dbg_w[i].box_y), m_y[i]);
            chk($sformatf("%s dx[%0d]", tag, i),    int'(dbg_w[i].dir_x == DIR_DEC), int'(m_dx[i] < 0));
            chk($sformatf("%s dy[%0d]", tag, i),    int'(dbg_w[i].dir_y == DIR_DEC), int'(m_dy[i] < 0));
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the following negedge.
    task automatic drive(input int px, input int py, input logic von,
                         input logic hs, input logic vs, input logic ps);
        vif.pixel_x  = 12'(px);
        vif.pixel_y  = 12'(py);
        vif.video_on = von;
        vif.hsync_in = hs;
        vif.vsync_in = vs;
        pause        = ps;
        #1;
        chk("rgb_before_edge", int'(rgb_w[0]), int'(m_rgb[0]));
        model_edge(px, py, von, hs, vs, ps);
        @(negedge clk);
    endtask

    typedef struct {
        int          px;
        int          py;
        logic        von;
        logic        hs;
        logic        vs;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t tbl [11];
    int   b_seq_x [4] = '{604, 606, 608, 606};
    int   b_seq_c [4] = '{0, 0, 1, 1};

    initial begin
        tbl[0]  = '{304, 224, 1'b1, 1'b1, 1'b1, 12'hF00};
        tbl[1]  = '{335, 255, 1'b1, 1'b0, 1'b1, 12'hF00};
        tbl[2]  = '{303, 224, 1'b1, 1'b1, 1'b0, 12'h00F};
        tbl[3]  = '{336, 240, 1'b1, 1'b0, 1'b0, 12'h00F};
        tbl[4]  = '{320, 223, 1'b1, 1'b1, 1'b1, 12'h00F};
        tbl[5]  = '{320, 256, 1'b1, 1'b1, 1'b1, 12'h00F};
        tbl[6]  = '{320, 240, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[7]  = '{0,   0,   1'b1, 1'b1, 1'b1, 12'h00F};
        tbl[8]  = '{639, 479, 1'b1, 1'b0, 1'b1, 12'h00F};
        tbl[9]  = '{320, 255, 1'b1, 1'b1, 1'b1, 12'hF00};
        tbl[10] = '{304, 255, 1'b0, 1'b0, 1'b0, 12'h000};

        rst_n = 1'b0;
        pause = 1'b0;
        vif.pixel_x = 12'd700; vif.pixel_y = 12'd500;
        vif.video_on = 1'b0; vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset box_x a", int'(dbg_w[0].box_x), 304);
        chk("reset box_y a", int'(dbg_w[0].box_y), 224);
        rst_n = 1'b1;
        drive(700, 500, 1'b0, 1'b1, 1'b1, 1'b0);

        // Draw window edges at the reset position, with syncs riding along.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].px, tbl[i].py, tbl[i].von, tbl[i].hs, tbl[i].vs, 1'b0);
            chk($sformatf("tbl%0d rgb", i), int'(rgb_w[0]), int'(tbl[i].exp_rgb));
            chk($sformatf("tbl%0d hs", i),  int'(hs_w[0]), int'(tbl[i].hs));
            chk($sformatf("tbl%0d vs", i),  int'(vs_w[0]), int'(tbl[i].vs));
            check_all("tbl");
        end

        // First frame tick.
        drive(0, 480, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("tick1 frame_tick", int'(ft_w[0]), 1);
        chk("tick1 box_x a", int'(dbg_w[0].box_x), 306);
        chk("tick1 box_y a", int'(dbg_w[0].box_y), 226);
        chk("tick1 cnt a", int'(cnt_w[0]), 0);
        chk("tick1 box_x b", int'(dbg_w[1].box_x), 602);
        chk("corner box_x c", int'(dbg_w[2].box_x), 608);
        chk("corner box_y c", int'(dbg_w[2].box_y), 448);
        chk("corner cnt c", int'(cnt_w[2]), 2);
        check_all("tick1");
        drive(1, 480, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("tick1 frame_tick low", int'(ft_w[0]), 0);
        check_all("tick1b");

        // Right-wall approach and bounce for the X0=600 instance.
        for (int k = 0; k < 4; k++) begin
            drive(0, 480, 1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("b seq%0d x", k), int'(dbg_w[1].box_x), b_seq_x[k]);
            chk($sformatf("b seq%0d cnt", k), int'(cnt_w[1]), b_seq_c[k]);
            check_all("bseq");
            drive(5, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        end

        // Three paused ticks: nothing moves, box still drawn.
        for (int k = 0; k < 3; k++) begin
            drive(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
            check_all("pause");
            drive(2, 481, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        chk("pause box_x a", int'(dbg_w[0].box_x), 314);
        chk("pause box_y a", int'(dbg_w[0].box_y), 234);
        chk("pause cnt b", int'(cnt_w[1]), 1);
        drive(320, 240, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("pause rgb a", int'(rgb_w[0]), 12'hF00);

        // Randomised pixels, ticks and pause against the model.
        for (int k = 0; k < 400; k++) begin
            int r;
            int px;
            int py;
            r = int'($urandom_range(0, 9));
            if (r < 2)       begin px = 0; py = 480; end
            else if (r == 2) begin px = 0; py = 34;  end
            else begin
                px = int'($urandom_range(0, 799));
                py = int'($urandom_range(0, 524));
            end
            drive(px, py, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
            check_all("rand");
        end

        // Saturate the small instance's counter: each tick hits both walls.
        for (int k = 0; k < 130; k++) drive(0, 34, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("sat");
        chk("sat cnt e", int'(cnt_w[3]), 255);

        // Asynchronous reset in the middle of a line.
        drive(100, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        #5;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_reset cnt e", int'(cnt_w[3]), 0);
        chk("async_reset hs a", int'(hs_w[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(310, 230, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("resume rgb a", int'(rgb_w[0]), 12'hF00);
        check_all("resume");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bounce_box_gen.md
Name: bounce_box_gen

Overview:
- Pixel-generation stage directly downstream of the VGA sync core. Consumes pixel_x, pixel_y, video_on, hsync and vsync.
- Draws a solid square that moves once per frame and bounces off the visible-area edges.
- Outputs registered 12-bit RGB with hsync/vsync re-timed to match. Intended as the demo/test-pattern source feeding the VGA DAC pins.

Parameters:
- HD, 640, visible width in pixels
- VD, 480, visible height in lines
- SIZE, 32, box edge length in pixels; must satisfy STEP < SIZE <= VD
- STEP, 2, pixels moved per axis per frame; must be >= 1
- X0, 304, reset x of the box's left column; X0+SIZE <= HD
- Y0, 224, reset y of the box's top row; Y0+SIZE <= VD
- BOX_COLOR, 12'hF00, RGB444 colour of the box
- BG_COLOR, 12'h00F, RGB444 colour of the visible background

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  reset
- video_on  in  1  visible-area flag from the sync core
- hsync_in  in  1  horizontal sync from the sync core, active low
- vsync_in  in  1  vertical sync from the sync core, active low
- pixel_x  in  12  current column
- pixel_y  in  12  current line
- pause  in  1  level; 1 freezes motion
- rgb  out  12  registered RGB444 pixel
- hsync_out  out  1  hsync_in delayed one cycle
- vsync_out  out  1  vsync_in delayed one cycle
- bounce_cnt  out  8  saturating count of wall hits
- frame_tick  out  1  registered one-cycle pulse, once per frame

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. Reset values:
  - rgb = 0
  - hsync_out = 1, vsync_out = 1
  - bounce_cnt = 0, frame_tick = 0
  - box_x = X0, box_y = Y0
  - x direction = right, y direction = down
- Reset mid-frame: all of the above apply immediately. No recovery handshake; drawing resumes on the next cycle after release.
- Tick detect (combinational): tick = (pixel_y == VD) && (pixel_x == 0).
  - Fires once per frame, inside vertical blanking, so the box never tears.
  - frame_tick is tick registered, i.e. it is high the cycle after the tick condition.
- Motion is updated on the clock edge where tick = 1 and pause = 0. With pause = 1, position, direction and bounce_cnt all hold.
- X axis, moving right:
  - If box_x + SIZE + STEP >= HD: box_x <= HD - SIZE, direction <= left, hit.
  - Else: box_x <= box_x + STEP.
- X axis, moving left:
  - If box_x <= STEP: box_x <= 0, direction <= right, hit.
  - Else: box_x <= box_x - STEP.
- Y axis uses the same rules with VD, box_y, down/up.
- All comparisons use 13-bit unsigned arithmetic, so there is no wrap-around.
- Hits:
  - Each axis hit adds 1 to bounce_cnt; a corner hit (both axes on the same tick) adds 2.
  - bounce_cnt saturates at 255 and never wraps.
- Draw stage (1-cycle latency):
  - box_on = box_x <= pixel_x < box_x + SIZE and box_y <= pixel_y < box_y + SIZE.
  - rgb <= !video_on ? 0 : box_on ? BOX_COLOR : BG_COLOR.
  - hsync_out <= hsync_in and vsync_out <= vsync_in on the same edge, so rgb and syncs stay aligned.
- The sync core may change its porch widths at runtime. The block is insensitive to this: it depends only on pixel coordinates and video_on.

Decomposition:
- Shared package/header vga_defs:
  - HD, VD, RGB width (12), colour constants
  - reset sync level (1)
- Sub-module box_axis, instantiated twice (x and y):
  - parameters LIMIT, SIZE, STEP, P0
  - inputs clk, rst_n, en (= tick && !pause)
  - outputs pos[11:0], hit (1-cycle pulse)
  - holds the position register, direction flop and bounce rule
- The top level holds tick detection, the bounce counter, the draw register and the sync delay.

Test Plan:
- Reset, then one tick (pixel_y=480, pixel_x=0) with pause=0 -> next cycle box_x=306, box_y=226, frame_tick=1 for exactly one cycle, bounce_cnt=0.
- Override X0=600, drive 5 ticks -> box_x sequence 602, 604, 606, 608 (direction flips, bounce_cnt=1), 606.
- Override X0=STEP=2 with direction forced left after a right-wall hit; or, simpler, X0=0 with Y0=VD-SIZE-2 -> the y hit at 448 increments bounce_cnt; a simultaneous x and y hit increments bounce_cnt by 2.
- pause=1 across 3 ticks -> box_x, box_y and bounce_cnt unchanged; rgb still shows the box.
- Sweep pixel_x/pixel_y over the box at reset position -> rgb=12'hF00 exactly for x in 304..335 and y in 224..255; 12'h00F elsewhere with video_on=1; 0 when video_on=0. Each rgb change lags its input by 1 cycle and equals the hsync_out/vsync_out lag.
- Force 260 hits, then assert rst_n=0 mid-line -> bounce_cnt=255 before reset; immediately after reset all outputs take their reset values and box returns to (304,224).
